// File: rtl/branch_trainer.sv
// Branch trainer: 2-bit saturating-counter BHT with power-up init sweep and mispredict redirect.
// Optional event counters are enabled by defining BHT_STATS_EN.
module branch_trainer #(
   parameter int BHT_IDX_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic        upd_pred,
   input  logic [31:0] upd_target,
   input  logic [31:0] query_pc,
   output logic        query_taken,
   output logic        init_busy,
   output logic        mispredict,
   output logic [31:0] redirect_pc
`ifdef BHT_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_misses
`endif
);

   localparam int ENTRIES = 1 << BHT_IDX_W;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
      logic [1:0] r;
      if (taken) begin
         r = (c == 2'b11) ? 2'b11 : c + 2'b01;
      end else begin
         r = (c == 2'b00) ? 2'b00 : c - 2'b01;
      end
      return r;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_t                 state_q, state_d;
   logic [BHT_IDX_W-1:0]   sweep_q, sweep_d;
   logic                   mispredict_q, mispredict_d;
   logic [31:0]            redirect_q, redirect_d;
   logic [1:0]             bht_q [ENTRIES];

   logic                   wr_en_s;
   logic [BHT_IDX_W-1:0]   wr_idx_s;
   logic [1:0]             wr_val_s;
   logic                   accept_s;
   logic                   miss_s;
   logic [BHT_IDX_W-1:0]   upd_idx_s;
   logic [BHT_IDX_W-1:0]   query_idx_s;
   logic                   unused_s;

   assign upd_idx_s   = upd_pc[BHT_IDX_W+1:2];
   assign query_idx_s = query_pc[BHT_IDX_W+1:2];
   assign unused_s    = ^{upd_pc[1:0], upd_pc[31:BHT_IDX_W+2], query_pc[1:0], query_pc[31:BHT_IDX_W+2]};

   assign init_busy   = (state_q == INIT);
   assign query_taken = (state_q == INIT) ? 1'b0 : bht_q[query_idx_s][1];
   assign mispredict  = mispredict_q;
   assign redirect_pc = redirect_q;

   // Next-state, table write port and flush outputs; rdy low holds everything.
   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      mispredict_d = mispredict_q;
      redirect_d   = redirect_q;
      wr_en_s      = 1'b0;
      wr_idx_s     = sweep_q;
      wr_val_s     = 2'b01;
      accept_s     = 1'b0;
      miss_s       = 1'b0;
      if (rdy) begin
         case (state_q)
            INIT: begin
               wr_en_s      = 1'b1;
               wr_idx_s     = sweep_q;
               wr_val_s     = 2'b01;
               sweep_d      = sweep_q + BHT_IDX_W'(1);
               mispredict_d = 1'b0;
               if (sweep_q == {BHT_IDX_W{1'b1}}) begin
                  state_d = RUN;
               end else begin
                  state_d = INIT;
               end
            end
            RUN: begin
               accept_s     = upd_valid;
               miss_s       = upd_valid & (upd_taken ^ upd_pred);
               mispredict_d = miss_s;
               if (accept_s) begin
                  wr_en_s  = 1'b1;
                  wr_idx_s = upd_idx_s;
                  wr_val_s = sat_step(bht_q[upd_idx_s], upd_taken);
               end else begin
                  wr_en_s  = 1'b0;
               end
               if (miss_s) begin
                  redirect_d = upd_taken ? upd_target : upd_pc + 32'd4;
               end else begin
                  redirect_d = redirect_q;
               end
            end
            default: begin
               state_d = INIT;
               sweep_d = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Control and flush registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= INIT;
         sweep_q      <= '0;
         mispredict_q <= 1'b0;
         redirect_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         mispredict_q <= mispredict_d;
         redirect_q   <= redirect_d;
      end
   end

   // Counter table; contents are established by the init sweep rather than by reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_en_s) begin
         bht_q[wr_idx_s] <= wr_val_s;
      end
   end

`ifdef BHT_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_misses_q, stat_misses_d;

   // Saturating event counters.
   always_comb begin
      stat_branches_d = accept_s ? sat_inc32(stat_branches_q) : stat_branches_q;
      stat_misses_d   = miss_s   ? sat_inc32(stat_misses_q)   : stat_misses_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_q <= 32'd0;
         stat_misses_q   <= 32'd0;
      end else begin
         stat_branches_q <= stat_branches_d;
         stat_misses_q   <= stat_misses_d;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_misses   = stat_misses_q;
`endif

endmodule

// File: tb/tb_branch_trainer.sv
// Directed self-checking bench for branch_trainer; stats checks compile only with BHT_STATS_EN.
module tb_branch_trainer;
   logic        clk = 1'b0;
   logic        rst, rdy, upd_valid, upd_taken, upd_pred;
   logic [31:0] upd_pc, upd_target, query_pc;
   logic        query_taken, init_busy, mispredict;
   logic [31:0] redirect_pc;
`ifdef BHT_STATS_EN
   logic [31:0] stat_branches, stat_misses;
`endif
   int n_tests = 0;
   int n_fail  = 0;

   branch_trainer #(.BHT_IDX_W(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_pred(upd_pred), .upd_target(upd_target),
      .query_pc(query_pc), .query_taken(query_taken), .init_busy(init_busy),
      .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BHT_STATS_EN
      , .stat_branches(stat_branches), .stat_misses(stat_misses)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_init();
      rst = 1'b1; rdy = 1'b1; upd_valid = 1'b0;
      step();
      rst = 1'b0;
      repeat (256) step();
   endtask

   task automatic upd(input logic [31:0] pc, input logic t, input logic p, input logic [31:0] tgt);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_pred = p; upd_target = tgt;
   endtask

   task automatic test_reset();
      int cnt;
      logic [31:0] pcs [4];
      pcs = '{32'h0, 32'h1000, 32'hFFC, 32'h400};
      rst = 1'b1; rdy = 1'b1; upd_valid = 1'b0; query_pc = 32'h0;
      step();
      n_tests++; if (init_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b want 1", init_busy); end
      n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL rst_mp got %b want 0", mispredict); end
      n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_redirect got %h want 0", redirect_pc); end
      n_tests++; if (query_taken !== 1'b0) begin n_fail++; $display("FAIL rst_query got %b want 0", query_taken); end
      rst = 1'b0;
      cnt = 0;
      while (init_busy === 1'b1 && cnt < 300) begin
         cnt++;
         step();
      end
      n_tests++; if (cnt != 256) begin n_fail++; $display("FAIL init_len got %0d want 256", cnt); end
      for (int i = 0; i < 4; i++) begin
         query_pc = pcs[i];
         #1;
         n_tests++; if (query_taken !== 1'b0) begin n_fail++; $display("FAIL init_query pc=%h got %b want 0", pcs[i], query_taken); end
      end
   endtask

   task automatic test_counter();
      do_init();
      query_pc = 32'h1000;
      upd(32'h1000, 1'b1, 1'b0, 32'h1100);
      #1;
      n_tests++; if (query_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_query got %b want 0", query_taken); end
      step();
      n_tests++; if (query_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_10 got %b want 1", query_taken); end
      n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h1100) begin n_fail++; $display("FAIL b2b_mp1 got %b/%h want 1/00001100", mispredict, redirect_pc); end
      upd_target = 32'h1200;
      step();
      n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h1200) begin n_fail++; $display("FAIL b2b_mp2 got %b/%h want 1/00001200", mispredict, redirect_pc); end
      upd_target = 32'h1300;
      step();
      n_tests++; if (query_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_11 got %b want 1", query_taken); end
      n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h1300) begin n_fail++; $display("FAIL b2b_mp3 got %b/%h want 1/00001300", mispredict, redirect_pc); end
      upd_taken = 1'b0;
      step();
      n_tests++; if (query_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_sat_dn1 got %b want 1", query_taken); end
      n_tests++; if (mispredict !== 1'b0 || redirect_pc !== 32'h1300) begin n_fail++; $display("FAIL redirect_hold got %b/%h want 0/00001300", mispredict, redirect_pc); end
      step();
      n_tests++; if (query_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_sat_dn2 got %b want 0", query_taken); end
      upd_valid = 1'b0;
   endtask

   task automatic test_mispredict();
      do_init();
      upd(32'h2000, 1'b0, 1'b1, 32'hDEAD_0000);
      step();
      upd_valid = 1'b0;
      n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h2004) begin n_fail++; $display("FAIL mp_nt got %b/%h want 1/00002004", mispredict, redirect_pc); end
      step();
      n_tests++; if (mispredict !== 1'b0 || redirect_pc !== 32'h2004) begin n_fail++; $display("FAIL mp_pulse got %b/%h want 0/00002004", mispredict, redirect_pc); end
      upd(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h5555_0000);
      step();
      upd_valid = 1'b0;
      n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL mp_wrap got %b/%h want 1/00000000", mispredict, redirect_pc); end
   endtask

   task automatic test_rdy();
      do_init();
      query_pc = 32'h3000;
      rdy = 1'b0;
      upd(32'h3000, 1'b1, 1'b0, 32'h3F00);
      step();
      n_tests++; if (mispredict !== 1'b0 || query_taken !== 1'b0) begin n_fail++; $display("FAIL rdy_drop got %b/%b want 0/0", mispredict, query_taken); end
      rdy = 1'b1;
      step();
      n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h3F00 || query_taken !== 1'b1) begin n_fail++; $display("FAIL rdy_accept got %b/%h/%b want 1/00003f00/1", mispredict, redirect_pc, query_taken); end
      rdy = 1'b0;
      upd(32'h3000, 1'b0, 1'b1, 32'h3F00);
      step();
      n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h3F00 || query_taken !== 1'b1) begin n_fail++; $display("FAIL rdy_hold got %b/%h/%b want 1/00003f00/1", mispredict, redirect_pc, query_taken); end
      rdy = 1'b1;
      upd_pred = 1'b0;
      step();
      upd_valid = 1'b0;
      n_tests++; if (mispredict !== 1'b0 || redirect_pc !== 32'h3F00 || query_taken !== 1'b0) begin n_fail++; $display("FAIL rdy_resume got %b/%h/%b want 0/00003f00/0", mispredict, redirect_pc, query_taken); end
   endtask

   task automatic test_reset_mid_sweep();
      int cnt;
      do_init();
      query_pc = 32'h14;
      upd(32'h14, 1'b1, 1'b1, 32'h0);
      step();
      upd_valid = 1'b0;
      n_tests++; if (query_taken !== 1'b1) begin n_fail++; $display("FAIL pre_rst_query got %b want 1", query_taken); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();
      n_tests++; if (init_busy !== 1'b1 || query_taken !== 1'b0) begin n_fail++; $display("FAIL init_force0 got %b/%b want 1/0", init_busy, query_taken); end
      repeat (97) step();
      rst = 1'b1; rdy = 1'b0;
      step();
      rst = 1'b0; rdy = 1'b1;
      upd(32'h14, 1'b1, 1'b0, 32'h9999);
      cnt = 0;
      while (init_busy === 1'b1 && cnt < 300) begin
         cnt++;
         n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL init_ignore_mp cycle %0d got %b want 0", cnt, mispredict); end
         step();
      end
      upd_valid = 1'b0;
      n_tests++; if (cnt != 256) begin n_fail++; $display("FAIL restart_len got %0d want 256", cnt); end
      n_tests++; if (mispredict !== 1'b0 || query_taken !== 1'b0) begin n_fail++; $display("FAIL init_ignore got %b/%b want 0/0", mispredict, query_taken); end
   endtask

`ifdef BHT_STATS_EN
   task automatic test_stats();
      logic [1:0] pat [5];
      pat = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
      do_init();
      for (int i = 0; i < 5; i++) begin
         upd(32'h100 + 32'(i * 4), pat[i][1], pat[i][0], 32'h0);
         step();
      end
      upd_valid = 1'b0;
      n_tests++; if (stat_branches !== 32'd5 || stat_misses !== 32'd2) begin n_fail++; $display("FAIL stats got %0d/%0d want 5/2", stat_branches, stat_misses); end
      force dut.stat_branches_q = 32'hFFFF_FFFF;
      force dut.stat_misses_q   = 32'hFFFF_FFFF;
      #1;
      release dut.stat_branches_q;
      release dut.stat_misses_q;
      upd(32'h200, 1'b1, 1'b0, 32'h0);
      step();
      upd_valid = 1'b0;
      n_tests++; if (stat_branches !== 32'hFFFF_FFFF || stat_misses !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stats_sat got %h/%h want ffffffff/ffffffff", stat_branches, stat_misses); end
   endtask
`endif

   initial begin
      rst = 1'b1; rdy = 1'b1; upd_valid = 1'b0; upd_taken = 1'b0; upd_pred = 1'b0;
      upd_pc = 32'h0; upd_target = 32'h0; query_pc = 32'h0;
      @(negedge clk);
      test_reset();
      test_counter();
      test_mispredict();
      test_rdy();
      test_reset_mid_sweep();
`ifdef BHT_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
